// File: rtl/clct_patid_pkg.sv
// Shared definitions for the CLCT pattern-ID encoder: default geometry,
// the per-BX case classification and the reserved-code helper.
package clct_patid_pkg;

  localparam int NPAT_DEF  = 5;
  localparam int PID_W_DEF = 3;
  localparam int OUT_W_DEF = 5;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    NONE,
    L0,
    PAIR,
    L1ONLY,
    ERR
  } patid_case_e;

  // Reserved codes sit at the top of the code space: all-ones for none/error,
  // all-ones minus one for a lone CLCT1.
  function automatic int unsigned reserved_code(input int unsigned out_w,
                                                input patid_case_e kind);
    int unsigned all1;
    all1 = (32'd1 << out_w) - 32'd1;
    return (kind == L1ONLY) ? all1 - 32'd1 : all1;
  endfunction

endpackage

// File: rtl/patid_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module patid_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clct_patid_encoder.sv
// Two-stage registered packer of both CLCTs' pattern IDs into one code.
// Define CLCT_PATID_STATS_EN to build the saturating event counters and cnt_clear.
module clct_patid_encoder
  import clct_patid_pkg::*;
#(
  parameter int NPAT  = NPAT_DEF,
  parameter int PID_W = PID_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  input  logic             lct0_vpf,
  input  logic [PID_W-1:0] clct0_pid,
  input  logic             lct1_vpf,
  input  logic [PID_W-1:0] clct1_pid,
`ifdef CLCT_PATID_STATS_EN
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_pair,
  output logic [CNT_W-1:0] cnt_lct1only,
  output logic [CNT_W-1:0] cnt_err,
`endif
  output logic             out_vld,
  output logic [OUT_W-1:0] out_pid,
  output logic             out_err
);

  localparam int               SUM_W   = OUT_W + 1;
  localparam logic [31:0]      NPAT_U  = 32'(NPAT);
  localparam logic [OUT_W-1:0] ALL1    = OUT_W'(reserved_code(OUT_W, NONE));
  localparam logic [OUT_W-1:0] L1_CODE = OUT_W'(reserved_code(OUT_W, L1ONLY));

  if (NPAT < 1 || CNT_W < 1) begin : g_bad_sizes
    $error("clct_patid_encoder: NPAT and CNT_W must be at least 1");
  end
  if ((64'd1 << PID_W) < 64'(NPAT)) begin : g_bad_pid_w
    $error("clct_patid_encoder: PID_W too narrow for NPAT");
  end
  if (64'(NPAT) * 64'(NPAT + 1) + 64'd2 > (64'd1 << OUT_W)) begin : g_bad_out_w
    $error("clct_patid_encoder: OUT_W too narrow for NPAT*(NPAT+1)+2 codes");
  end

  // ---------------- stage 1: classify and pre-multiply ----------------
  logic             pid0_bad, pid1_bad;
  patid_case_e      in_case;
  logic [SUM_W-1:0] pid1_ext, pid1_x_npat;

  always_comb begin
    pid0_bad = lct0_vpf && (32'(clct0_pid) >= NPAT_U);
    pid1_bad = lct1_vpf && (32'(clct1_pid) >= NPAT_U);
    if (pid0_bad || pid1_bad)      in_case = ERR;
    else if (lct0_vpf && !lct1_vpf) in_case = L0;
    else if (lct0_vpf && lct1_vpf)  in_case = PAIR;
    else if (lct1_vpf)              in_case = L1ONLY;
    else                            in_case = NONE;
  end

  // Constant-coefficient multiply unrolled into shift-adds over NPAT's set bits.
  // NOTE: blocking '=' is correct here; the accumulator must see its own
  // previous iteration within one evaluation of the combinational block.
  always_comb begin
    pid1_ext    = SUM_W'(clct1_pid);
    pid1_x_npat = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (NPAT_U[i]) pid1_x_npat = pid1_x_npat + (pid1_ext << i);
    end
  end

  logic             s1_vld;
  patid_case_e      s1_case;
  logic [SUM_W-1:0] s1_pid0, s1_pid1_x_npat;

  // NOTE: only the valid bit is reset; the data registers are qualified by it,
  // so resetting them would add reset fan-out with no functional effect.
  always_ff @(posedge clock) begin
    if (reset) s1_vld <= 1'b0;
    else       s1_vld <= in_vld;
    if (in_vld) begin
      s1_case        <= in_case;
      s1_pid0        <= SUM_W'(clct0_pid);
      s1_pid1_x_npat <= pid1_x_npat;
    end
  end

  // ---------------- stage 2: final sum and code mux ----------------
  logic [SUM_W-1:0] pair_sum;
  logic [OUT_W-1:0] code_next;

  // NOTE: every branch assigns code_next (default included), so no latch.
  always_comb begin
    pair_sum = SUM_W'(NPAT) + s1_pid1_x_npat + s1_pid0;
    case (s1_case)
      L0:      code_next = OUT_W'(s1_pid0);
      PAIR:    code_next = OUT_W'(pair_sum);
      L1ONLY:  code_next = L1_CODE;
      default: code_next = ALL1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_pid <= ALL1;
      out_err <= 1'b0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_pid <= code_next;
        out_err <= (s1_case == ERR);
      end
    end
  end

`ifdef CLCT_PATID_STATS_EN
  // ---------------- event statistics ----------------
  patid_case_e out_case;

  always_ff @(posedge clock) begin
    if (s1_vld) out_case <= s1_case;
  end

  patid_sat_counter #(.CNT_W(CNT_W)) u_cnt_single (
    .clock(clock), .reset(reset), .clear(cnt_clear),
    .inc(out_vld && (out_case == L0)), .count(cnt_single)
  );
  patid_sat_counter #(.CNT_W(CNT_W)) u_cnt_pair (
    .clock(clock), .reset(reset), .clear(cnt_clear),
    .inc(out_vld && (out_case == PAIR)), .count(cnt_pair)
  );
  patid_sat_counter #(.CNT_W(CNT_W)) u_cnt_lct1only (
    .clock(clock), .reset(reset), .clear(cnt_clear),
    .inc(out_vld && (out_case == L1ONLY)), .count(cnt_lct1only)
  );
  patid_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
    .clock(clock), .reset(reset), .clear(cnt_clear),
    .inc(out_vld && (out_case == ERR)), .count(cnt_err)
  );
`endif

endmodule

// File: tb/tb_clct_patid_encoder.sv
// Randomised plus directed bench for clct_patid_encoder against a
// code-table reference model; a second instance covers NPAT=9 geometry.
module tb_clct_patid_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_vld = 1'b0, lct0_vpf = 1'b0, lct1_vpf = 1'b0;
  logic [2:0] clct0_pid = '0, clct1_pid = '0;
  logic       out_vld, out_err;
  logic [4:0] out_pid;

  logic       b_in_vld = 1'b0, b_lct0_vpf = 1'b0, b_lct1_vpf = 1'b0;
  logic [3:0] b_clct0_pid = '0, b_clct1_pid = '0;
  logic       b_out_vld, b_out_err;
  logic [6:0] b_out_pid;

`ifdef CLCT_PATID_STATS_EN
  logic        cnt_clear = 1'b0, b_cnt_clear = 1'b0;
  logic [3:0]  cnt_single, cnt_pair, cnt_lct1only, cnt_err;
  logic [15:0] b_cnt_single, b_cnt_pair, b_cnt_lct1only, b_cnt_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  clct_patid_encoder #(.NPAT(5), .PID_W(3), .OUT_W(5), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .in_vld(in_vld),
    .lct0_vpf(lct0_vpf), .clct0_pid(clct0_pid),
    .lct1_vpf(lct1_vpf), .clct1_pid(clct1_pid),
`ifdef CLCT_PATID_STATS_EN
    .cnt_clear(cnt_clear), .cnt_single(cnt_single), .cnt_pair(cnt_pair),
    .cnt_lct1only(cnt_lct1only), .cnt_err(cnt_err),
`endif
    .out_vld(out_vld), .out_pid(out_pid), .out_err(out_err)
  );

  clct_patid_encoder #(.NPAT(9), .PID_W(4), .OUT_W(7), .CNT_W(16)) dut_big (
    .clock(clock), .reset(reset), .in_vld(b_in_vld),
    .lct0_vpf(b_lct0_vpf), .clct0_pid(b_clct0_pid),
    .lct1_vpf(b_lct1_vpf), .clct1_pid(b_clct1_pid),
`ifdef CLCT_PATID_STATS_EN
    .cnt_clear(b_cnt_clear), .cnt_single(b_cnt_single), .cnt_pair(b_cnt_pair),
    .cnt_lct1only(b_cnt_lct1only), .cnt_err(b_cnt_err),
`endif
    .out_vld(b_out_vld), .out_pid(b_out_pid), .out_err(b_out_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 none, 1 single, 2 pair, 3 lct1-only, 4 error
  typedef struct {
    bit vld;
    int code;
    bit err;
    int kind;
  } pred_t;

  function automatic pred_t predict(input bit vld, input bit v0, input int p0,
                                    input bit v1, input int p1,
                                    input int npat, input int out_w);
    pred_t r;
    int all1;
    all1  = (1 << out_w) - 1;
    r.vld = vld;
    r.err = 1'b0;
    if ((v0 && p0 >= npat) || (v1 && p1 >= npat)) begin
      r.code = all1; r.err = 1'b1; r.kind = 4;
    end else if (v0 && v1) begin
      r.code = npat + p1 * npat + p0; r.kind = 2;
    end else if (v0) begin
      r.code = p0; r.kind = 1;
    end else if (v1) begin
      r.code = all1 - 1; r.kind = 3;
    end else begin
      r.code = all1; r.kind = 0;
    end
    return r;
  endfunction

  pred_t q[$];
  int    held_code = 31;
  bit    held_err  = 1'b0;
  int    exp_cnt[5] = '{0, 0, 0, 0, 0};
  int    pending_kind = 0;

  // One clock of the main instance: drive, clock, then compare against model.
  task automatic step(input bit vld, input bit v0, input int p0,
                      input bit v1, input int p1, input bit rst, input bit clr);
    pred_t e;
    bit    exp_vld;
    reset     = rst;
    in_vld    = vld;
    lct0_vpf  = v0;
    clct0_pid = 3'(p0);
    lct1_vpf  = v1;
    clct1_pid = 3'(p1);
`ifdef CLCT_PATID_STATS_EN
    cnt_clear = clr;
`endif
    q.push_back(predict(vld, v0, p0, v1, p1, 5, 5));
    @(posedge clock);
    #1;
    exp_vld = 1'b0;
    e.kind  = 0;
    if (rst) begin
      q.delete();
      held_code = 31;
      held_err  = 1'b0;
    end else if (q.size() == 2) begin
      e = q.pop_front();
      exp_vld = e.vld;
      if (e.vld) begin
        held_code = e.code;
        held_err  = e.err;
      end
    end
    if (rst || clr) begin
      foreach (exp_cnt[k]) exp_cnt[k] = 0;
    end else if (pending_kind > 0 && exp_cnt[pending_kind] < 15) begin
      exp_cnt[pending_kind]++;
    end
    pending_kind = exp_vld ? e.kind : 0;

    check("out_vld", int'(out_vld), int'(exp_vld));
    check("out_pid", int'(out_pid), held_code);
    check("out_err", int'(out_err), int'(held_err));
`ifdef CLCT_PATID_STATS_EN
    check("cnt_single",   int'(cnt_single),   exp_cnt[1]);
    check("cnt_pair",     int'(cnt_pair),     exp_cnt[2]);
    check("cnt_lct1only", int'(cnt_lct1only), exp_cnt[3]);
    check("cnt_err",      int'(cnt_err),      exp_cnt[4]);
`endif
  endtask

  // Single transaction on the NPAT=9 instance with the expected code given directly.
  task automatic big_run(input string tag, input bit v0, input int p0,
                         input bit v1, input int p1,
                         input int exp_code, input bit exp_err);
    b_in_vld    = 1'b1;
    b_lct0_vpf  = v0;
    b_clct0_pid = 4'(p0);
    b_lct1_vpf  = v1;
    b_clct1_pid = 4'(p1);
    @(posedge clock);
    #1;
    b_in_vld = 1'b0;
    check({tag, "_vld_early"}, int'(b_out_vld), 0);
    @(posedge clock);
    #1;
    check({tag, "_vld"}, int'(b_out_vld), 1);
    check({tag, "_pid"}, int'(b_out_pid), exp_code);
    check({tag, "_err"}, int'(b_out_err), int'(exp_err));
    @(posedge clock);
    #1;
    check({tag, "_vld_drop"}, int'(b_out_vld), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (3) step(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);

    // Directed code-table cases and boundaries.
    step(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4, 1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
    for (int p1 = 0; p1 < 5; p1++)
      for (int p0 = 0; p0 < 5; p0++)
        step(1'b1, 1'b1, p0, 1'b1, p1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5, 1'b0, 7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2, 1'b1, 6, 1'b0, 1'b0);
    step(1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 6, 1'b1, 1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);

    // Back-to-back stream with reset pulsed mid-stream.
    for (int c = 0; c < 100; c++)
      step(1'b1, ($urandom_range(1, 0) == 1), int'($urandom_range(7, 0)),
           ($urandom_range(1, 0) == 1), int'($urandom_range(7, 0)),
           (c == 50), 1'b0);

    // Counter saturation, then clear coincident with an increment.
    for (int c = 0; c < 20; c++)
      step(1'b1, 1'b1, int'($urandom_range(4, 0)), 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 2, 1'b0, 0, 1'b0, 1'b0);

    // Random traffic with occasional reset and clear.
    for (int c = 0; c < 400; c++)
      step(($urandom_range(3, 0) != 0), ($urandom_range(1, 0) == 1),
           int'($urandom_range(7, 0)), ($urandom_range(1, 0) == 1),
           int'($urandom_range(7, 0)), ($urandom_range(63, 0) == 0),
           ($urandom_range(31, 0) == 0));
    repeat (3) step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Wider geometry: NPAT=9, PID_W=4, OUT_W=7.
    big_run("big_pair88",  1'b1, 8, 1'b1, 8, 89,  1'b0);
    big_run("big_pair00",  1'b1, 0, 1'b1, 0, 9,   1'b0);
    big_run("big_pair35",  1'b1, 3, 1'b1, 5, 57,  1'b0);
    big_run("big_single",  1'b1, 8, 1'b0, 0, 8,   1'b0);
    big_run("big_l1only",  1'b0, 0, 1'b1, 4, 126, 1'b0);
    big_run("big_none",    1'b0, 0, 1'b0, 0, 127, 1'b0);
    big_run("big_err",     1'b1, 9, 1'b1, 2, 127, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
